// File: rtl/lc2k_mem_requester_if.sv
// Word-addressed req/ack bus between the LC2K memory requester (master) and data memory (slave).
interface lc2k_mem_requester_if #(
    parameter int ADDR_W = 6
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/lc2k_mem_requester.sv
// LC2K load/store initiator: one command at a time over a req/ack memory handshake,
// with an address range check, a bounded wait and a registered completion pulse.
module lc2k_mem_requester #(
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_write,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          rdata,
    lc2k_mem_requester_if.master mem
);

    localparam logic [31:0] DEPTH_C   = 32'(DEPTH);
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    // Wait counter sticks at its maximum rather than wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                if (start) begin
                    is_write_d  = is_write;
                    mem_addr_d  = addr[ADDR_W-1:0];
                    mem_wdata_d = wdata;
                    busy_d      = 1'b1;
                    cnt_d       = 8'd0;
                    // Out-of-range addresses complete immediately and never touch the bus.
                    if (addr >= DEPTH_C) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        mem_req_d = 1'b1;
                        mem_we_d  = is_write;
                    end
                end
            end

            ISSUE: begin
                if (mem.mem_ack) begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!is_write_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                end else begin
                    // Ack is tested first, so an ack in the expiry cycle still succeeds.
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_d == TIMEOUT_C) begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            is_write_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lc2k_mem_requester.sv
// Directed plus randomized bench for lc2k_mem_requester against a transaction-level
// model of completion timing, error outcome and memory/rdata contents.
module tb_lc2k_mem_requester;

    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    lc2k_mem_requester_if #(.ADDR_W(ADDR_W)) mif ();

    lc2k_mem_requester #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .is_write(is_write),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .mem     (mif)
    );

    logic [31:0] slave_mem [DEPTH];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/busy"},      32'(busy),          32'd0);
        check({tag, "/done"},      32'(done),          32'd0);
        check({tag, "/err"},       32'(err),           32'd0);
        check({tag, "/mem_req"},   32'(mif.mem_req),   32'd0);
        check({tag, "/mem_we"},    32'(mif.mem_we),    32'd0);
        check({tag, "/rdata"},     rdata,              32'd0);
        check({tag, "/mem_addr"},  32'(mif.mem_addr),  32'd0);
        check({tag, "/mem_wdata"}, mif.mem_wdata,      32'd0);
    endtask

    // ack_cyc: request cycle in which memory acks (0 = never); spam: random start/idle-ack noise.
    task automatic run_cmd(input string tag, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input int ack_cyc, input bit spam);
        bit          range_err, exp_err;
        int          exp_done, exp_req;
        logic [31:0] exp_rd;
        logic [5:0]  wa;
        int          cyc, done_at, done_cnt, req_cyc, busy_cyc;
        bit          err_seen, err_stray, bus_ok, rd_ok;

        range_err = (a >= 32'(DEPTH));
        if (range_err) begin
            exp_done = 1;
            exp_err  = 1'b1;
        end else if (ack_cyc >= 1 && ack_cyc <= TIMEOUT) begin
            exp_done = ack_cyc + 1;
            exp_err  = 1'b0;
        end else begin
            exp_done = TIMEOUT + 1;
            exp_err  = 1'b1;
        end
        exp_req = range_err ? 0 : exp_done - 1;
        wa      = a[5:0];
        exp_rd  = (!w && !exp_err) ? model_mem[wa] : model_rdata;

        @(negedge clk);
        start    = 1'b1;
        is_write = w;
        addr     = a;
        wdata    = d;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;

        cyc = 1; done_at = 0; done_cnt = 0; req_cyc = 0; busy_cyc = 0;
        err_seen = 1'b0; err_stray = 1'b0; bus_ok = 1'b1; rd_ok = 1'b1;
        while (cyc <= 60 && !(done_at != 0 && cyc > done_at + 1)) begin
            if (mif.mem_req) begin
                req_cyc++;
                if (mif.mem_addr !== wa || mif.mem_we !== w || mif.mem_wdata !== d) bus_ok = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
                err_seen = err;
            end else if (err !== 1'b0) begin
                err_stray = 1'b1;
            end
            if (done_at == 0 ? (rdata !== model_rdata) : (rdata !== exp_rd)) rd_ok = 1'b0;

            mif.mem_ack   = (cyc == ack_cyc) || (spam && !mif.mem_req && $urandom_range(0, 1) == 1);
            mif.mem_rdata = slave_mem[mif.mem_addr];
            if (mif.mem_ack && mif.mem_req && mif.mem_we) slave_mem[mif.mem_addr] = mif.mem_wdata;
            start = spam && (done_at == 0 || done_at == cyc) && $urandom_range(0, 1) == 1;
            if (start) begin
                is_write = 1'($urandom_range(0, 1));
                addr     = $urandom_range(0, 63);
                wdata    = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        start       = 1'b0;
        mif.mem_ack = 1'b0;

        check({tag, "/done_cycle"},    32'(done_at),   32'(exp_done));
        check({tag, "/done_count"},    32'(done_cnt),  32'd1);
        check({tag, "/err"},           32'(err_seen),  32'(exp_err));
        check({tag, "/req_cycles"},    32'(req_cyc),   32'(exp_req));
        check({tag, "/busy_cycles"},   32'(busy_cyc),  32'(exp_done));
        check({tag, "/bus_stable"},    32'(bus_ok),    32'd1);
        check({tag, "/err_qualified"}, 32'(err_stray), 32'd0);
        check({tag, "/rdata_track"},   32'(rd_ok),     32'd1);
        check({tag, "/rdata_final"},   rdata,          exp_rd);

        if (!exp_err) begin
            if (w) model_mem[wa] = d;
            else   model_rdata   = model_mem[wa];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_done, seen_req;

        rst_n = 1'b0; start = 1'b0; is_write = 1'b0; addr = '0; wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slave_mem[i] = $urandom;
            model_mem[i] = slave_mem[i];
        end
        model_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        slave_mem[9] = 32'd1;
        model_mem[9] = 32'd1;
        run_cmd("zero_wait_load", 1'b0, 32'd9, 32'd0, 1, 1'b0);
        run_cmd("store11",        1'b1, 32'd11, 32'd8, 3, 1'b0);
        run_cmd("load11",         1'b0, 32'd11, 32'd0, 3, 1'b0);
        run_cmd("range64",        1'b0, 32'd64, 32'd0, 1, 1'b0);
        run_cmd("range_max",      1'b0, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        run_cmd("timeout_load",   1'b0, 32'd5, 32'd0, 0, 1'b0);
        run_cmd("ack_at_limit",   1'b0, 32'd12, 32'd0, 16, 1'b0);
        run_cmd("timeout_store",  1'b1, 32'd13, 32'h1234, 0, 1'b0);
        run_cmd("load13",         1'b0, 32'd13, 32'd0, 2, 1'b0);
        run_cmd("spam_load",      1'b0, 32'd30, 32'd0, 4, 1'b1);
        run_cmd("spam_store",     1'b1, 32'd31, 32'hCAFE, 2, 1'b1);
        run_cmd("spam_load31",    1'b0, 32'd31, 32'd0, 1, 1'b1);
        run_cmd("spam_range",     1'b0, 32'd100, 32'd0, 1, 1'b1);

        // Memory acking with no request outstanding must be ignored.
        repeat (4) begin
            @(negedge clk);
            check("idle_ack/mem_req", 32'(mif.mem_req), 32'd0);
            check("idle_ack/done",    32'(done),        32'd0);
            check("idle_ack/busy",    32'(busy),        32'd0);
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        mif.mem_ack = 1'b0;
        check("idle_ack/rdata", rdata, model_rdata);

        // Reset asserted in the second wait cycle of a load.
        @(negedge clk);
        start = 1'b1; is_write = 1'b0; addr = 32'd20; wdata = 32'd0;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid/req_c1", 32'(mif.mem_req), 32'd1);
        @(negedge clk);
        check("rst_mid/req_c2", 32'(mif.mem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        rst_n = 1'b1;
        model_rdata = 32'd0;
        seen_done = 1'b0; seen_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done)        seen_done = 1'b1;
            if (mif.mem_req) seen_req  = 1'b1;
        end
        check("rst_mid/no_done", 32'(seen_done), 32'd0);
        check("rst_mid/no_req",  32'(seen_req),  32'd0);
        run_cmd("post_rst_load", 1'b0, 32'd11, 32'd0, 2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            run_cmd($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), ra, $urandom,
                    $urandom_range(0, 18), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
